// File: rtl/h264_tc_pkg.sv
// -----------------------------------------------------------------------------
// h264_tc_pkg
// Shared definitions for the H.264 4x4 transform-coder blocks:
//   - MF (forward quantiser) and V (rescale) tables, indexed [QP%6][class]
//   - position-class enum and class_of() for a raster index 4*row+col
//   - coefficient / residual array typedefs
// No ports (package).
// -----------------------------------------------------------------------------
package h264_tc_pkg;

    localparam int COEF_W = 32;

    typedef enum logic [1:0] {
        POS_A = 2'd0,
        POS_B = 2'd1,
        POS_C = 2'd2
    } pos_class_t;

    localparam logic [13:0] MF_TABLE [6][3] = '{
        '{14'd13107, 14'd5243, 14'd8066},
        '{14'd11916, 14'd4660, 14'd7490},
        '{14'd10082, 14'd4194, 14'd6554},
        '{14'd9362,  14'd3647, 14'd5825},
        '{14'd8192,  14'd3355, 14'd5243},
        '{14'd7282,  14'd2893, 14'd4559}
    };

    localparam logic [4:0] V_TABLE [6][3] = '{
        '{5'd10, 5'd16, 5'd13},
        '{5'd11, 5'd18, 5'd14},
        '{5'd13, 5'd20, 5'd16},
        '{5'd14, 5'd23, 5'd18},
        '{5'd16, 5'd25, 5'd20},
        '{5'd18, 5'd29, 5'd23}
    };

    typedef logic signed [COEF_W-1:0] coef_arr_t [16];
    typedef logic signed [7:0]        resid_arr_t [16];

    // Row parity lives in index bit 2, column parity in bit 0.
    function automatic pos_class_t class_of(input logic [3:0] index);
        if (!index[2] && !index[0]) begin
            return POS_A;
        end else if (index[2] && index[0]) begin
            return POS_B;
        end else begin
            return POS_C;
        end
    endfunction

    // QP%6 codes 6 and 7 are not legal; they fall back to row 0.
    function automatic logic [2:0] qp_mod_clamp(input logic [2:0] qp_mod);
        return (qp_mod > 3'd5) ? 3'd0 : qp_mod;
    endfunction

    function automatic logic [13:0] mf_of(input logic [2:0] qp_mod, input pos_class_t cls);
        return MF_TABLE[qp_mod_clamp(qp_mod)][cls];
    endfunction

    function automatic logic [4:0] v_of(input logic [2:0] qp_mod, input pos_class_t cls);
        return V_TABLE[qp_mod_clamp(qp_mod)][cls];
    endfunction

endpackage

// File: rtl/idct_butterfly_4.sv
// -----------------------------------------------------------------------------
// idct_butterfly_4
// One-dimensional 4-point H.264 inverse core transform (butterfly form).
// Ports:
//   d0..d3  in   WIDTH signed  input samples along one row or column
//   f0..f3  out  WIDTH signed  transformed samples
// -----------------------------------------------------------------------------
module idct_butterfly_4 #(
    parameter int WIDTH = 38
) (
    input  logic signed [WIDTH-1:0] d0,
    input  logic signed [WIDTH-1:0] d1,
    input  logic signed [WIDTH-1:0] d2,
    input  logic signed [WIDTH-1:0] d3,
    output logic signed [WIDTH-1:0] f0,
    output logic signed [WIDTH-1:0] f1,
    output logic signed [WIDTH-1:0] f2,
    output logic signed [WIDTH-1:0] f3
);

    logic signed [WIDTH-1:0] e0, e1, e2, e3;

    // Odd terms use the half-weight taps as arithmetic right shifts.
    always_comb begin
        e0 = d0 + d2;
        e1 = d0 - d2;
        e2 = (d1 >>> 1) - d3;
        e3 = d1 + (d3 >>> 1);
        f0 = e0 + e3;
        f1 = e1 + e2;
        f2 = e1 - e2;
        f3 = e0 - e3;
    end

endmodule

// File: rtl/qrecon_4x4.sv
// -----------------------------------------------------------------------------
// qrecon_4x4
// H.264 4x4 quantise / reconstruct path. Three registered stages, each with
// its own enable: quant -> invquant -> invtran.
// Ports:
//   clk          in   1                     rising-edge clock
//   reset        in   1                     asynchronous, active-high reset
//   enable       in   3                     [0] quant, [1] invquant, [2] invtran
//   mode         in   1                     rounding: 0 intra (2^qbits/3), 1 inter (2^qbits/6)
//   QP_BY_6      in   4                     QP/6
//   QP_MOD_6     in   3                     QP%6 (6,7 treated as 0)
//   transformed  in   16 x (BIT_LENGTH+1)   forward-transform coefficients, index 4*row+col
//   quantized    out  16 x (BIT_LENGTH+1)   quantised levels (quant stage register)
//   residuals    out  16 x 8                reconstructed residuals (invtran stage register)
// Configuration macro:
//   QRECON_SAT_EN  defined: residuals saturate to [-128,127]
//                  undefined: residuals are the low byte of the rounded result
// -----------------------------------------------------------------------------
module qrecon_4x4
    import h264_tc_pkg::*;
#(
    parameter int BIT_LENGTH = 31
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 enable,
    input  logic                       mode,
    input  logic [3:0]                 QP_BY_6,
    input  logic [2:0]                 QP_MOD_6,
    input  logic signed [BIT_LENGTH:0] transformed [16],
    output logic signed [BIT_LENGTH:0] quantized [16],
    output logic signed [7:0]          residuals [16]
);

    localparam int CW = BIT_LENGTH + 1;
    localparam int PW = BIT_LENGTH + 17;
    localparam int IW = BIT_LENGTH + 7;

    localparam logic [PW-1:0]        ONE_P      = PW'(1);
    localparam logic [PW-1:0]        THREE_P    = PW'(3);
    localparam logic [PW-1:0]        SIX_P      = PW'(6);
    localparam logic signed [IW-1:0] ROUND_HALF = IW'(32);
    localparam logic signed [IW-1:0] SAT_HI     = IW'(127);
    localparam logic signed [IW-1:0] SAT_LO     = -IW'(128);

    logic [4:0]           qbits;
    logic [PW-1:0]        round_f;
    logic signed [CW-1:0] q_next  [16];
    logic signed [CW-1:0] wq_next [16];
    logic signed [CW-1:0] wq_reg  [16];
    logic signed [IW-1:0] row_in  [16];
    logic signed [IW-1:0] row_out [16];
    logic signed [IW-1:0] col_out [16];
    resid_arr_t           r_next;

    // Sign-magnitude quantisation so rounding is symmetric about zero.
    function automatic logic signed [CW-1:0] quant_lane(
        input logic signed [CW-1:0] w,
        input logic [13:0]          mf,
        input logic [4:0]           shift,
        input logic [PW-1:0]        f
    );
        logic [CW-1:0] mag_in;
        logic [PW-1:0] acc;
        logic [CW-1:0] mag_out;
        mag_in  = w[CW-1] ? -w : w;
        acc     = PW'(mag_in) * PW'(mf) + f;
        mag_out = CW'(acc >> shift);
        return w[CW-1] ? -$signed(mag_out) : $signed(mag_out);
    endfunction

    function automatic logic signed [CW-1:0] dequant_lane(
        input logic signed [CW-1:0] z,
        input logic [4:0]           v,
        input logic [3:0]           shift
    );
        logic signed [CW-1:0] v_word;
        v_word = $signed(CW'(v));
        return (z * v_word) <<< shift;
    endfunction

    // Final rounding (floor of (x+32)/64) and narrowing to 8 bits.
    function automatic logic signed [7:0] finish_lane(input logic signed [IW-1:0] x);
        logic signed [IW-1:0] scaled;
        scaled = (x + ROUND_HALF) >>> 6;
`ifdef QRECON_SAT_EN
        if (scaled > SAT_HI) begin
            return 8'sd127;
        end else if (scaled < SAT_LO) begin
            return -8'sd128;
        end else begin
            return scaled[7:0];
        end
`else
        return scaled[7:0];
`endif
    endfunction

    always_comb begin
        qbits   = 5'd15 + {1'b0, QP_BY_6};
        round_f = mode ? ((ONE_P << qbits) / SIX_P) : ((ONE_P << qbits) / THREE_P);
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            q_next[i]  = quant_lane(transformed[i], mf_of(QP_MOD_6, class_of(4'(i))), qbits, round_f);
            wq_next[i] = dequant_lane(quantized[i], v_of(QP_MOD_6, class_of(4'(i))), QP_BY_6);
            row_in[i]  = IW'(wq_reg[i]);
            r_next[i]  = finish_lane(col_out[i]);
        end
    end

    // Horizontal pass on each row, then vertical pass on each column.
    for (genvar g = 0; g < 4; g++) begin : g_rows
        idct_butterfly_4 #(.WIDTH(IW)) u_row (
            .d0(row_in[4*g]),   .d1(row_in[4*g+1]),  .d2(row_in[4*g+2]),  .d3(row_in[4*g+3]),
            .f0(row_out[4*g]),  .f1(row_out[4*g+1]), .f2(row_out[4*g+2]), .f3(row_out[4*g+3])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_cols
        idct_butterfly_4 #(.WIDTH(IW)) u_col (
            .d0(row_out[g]),  .d1(row_out[4+g]),  .d2(row_out[8+g]),  .d3(row_out[12+g]),
            .f0(col_out[g]),  .f1(col_out[4+g]),  .f2(col_out[8+g]),  .f3(col_out[12+g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                quantized[i] <= '0;
                wq_reg[i]    <= '0;
                residuals[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (enable[0]) quantized[i] <= q_next[i];
                if (enable[1]) wq_reg[i]    <= wq_next[i];
                if (enable[2]) residuals[i] <= r_next[i];
            end
        end
    end

endmodule

// File: tb/tb_qrecon_4x4.sv
// -----------------------------------------------------------------------------
// tb_qrecon_4x4
// Self-checking bench for qrecon_4x4. A cycle-level reference model (plain
// integer arithmetic on whole 4x4 blocks) tracks the three stage registers;
// a compare process checks both output arrays against it every cycle, and
// directed literal expectations pin specific values.
// -----------------------------------------------------------------------------
module tb_qrecon_4x4;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         enable;
    logic               mode;
    logic [3:0]         qp_by_6;
    logic [2:0]         qp_mod_6;
    logic signed [31:0] transformed [16];
    logic signed [31:0] quantized   [16];
    logic signed [7:0]  residuals   [16];

    int n_compared   = 0;
    int n_mismatched = 0;

    int m_q   [16];
    int m_wq  [16];
    int m_res [16];

    int mf_tab [6][3] = '{'{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
                          '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}};
    int v_tab  [6][3] = '{'{10, 16, 13}, '{11, 18, 14}, '{13, 20, 16},
                          '{14, 23, 18}, '{16, 25, 20}, '{18, 29, 23}};

    always #5 clk = ~clk;

    qrecon_4x4 dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .mode(mode),
        .QP_BY_6(qp_by_6),
        .QP_MOD_6(qp_mod_6),
        .transformed(transformed),
        .quantized(quantized),
        .residuals(residuals)
    );

    // ---------------- reference model ----------------
    function automatic int pos_cls(int idx);
        int r = idx / 4;
        int c = idx % 4;
        if ((r % 2 == 0) && (c % 2 == 0)) return 0;
        if ((r % 2 == 1) && (c % 2 == 1)) return 1;
        return 2;
    endfunction

    function automatic int model_quant(int w, int qpb, int qpm, bit md, int idx);
        longint a, f, z;
        int qm = (qpm > 5) ? 0 : qpm;
        int qb = 15 + qpb;
        f = (longint'(1) << qb) / (md ? 6 : 3);
        a = (w < 0) ? -longint'(w) : longint'(w);
        z = (a * mf_tab[qm][pos_cls(idx)] + f) >> qb;
        return int'((w < 0) ? -z : z);
    endfunction

    function automatic int model_dequant(int z, int qpb, int qpm, int idx);
        int qm = (qpm > 5) ? 0 : qpm;
        longint p = (longint'(z) * v_tab[qm][pos_cls(idx)]) << qpb;
        return int'(p);
    endfunction

    function automatic void idct4(input longint a[4], output longint y[4]);
        longint even0 = a[0] + a[2];
        longint even1 = a[0] - a[2];
        longint odd0  = a[1] + (a[3] >>> 1);
        longint odd1  = (a[1] >>> 1) - a[3];
        y[0] = even0 + odd0;
        y[1] = even1 + odd1;
        y[2] = even1 - odd1;
        y[3] = even0 - odd0;
    endfunction

    function automatic void model_recon(input int wq[16], output int res[16]);
        longint blk [4][4];
        longint t [4];
        longint y [4];
        longint s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) blk[r][c] = wq[4*r+c];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) t[c] = blk[r][c];
            idct4(t, y);
            for (int c = 0; c < 4; c++) blk[r][c] = y[c];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) t[r] = blk[r][c];
            idct4(t, y);
            for (int r = 0; r < 4; r++) blk[r][c] = y[r];
        end
        for (int i = 0; i < 16; i++) begin
            s = (blk[i/4][i%4] + 32) >>> 6;
`ifdef QRECON_SAT_EN
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            res[i] = int'(s);
`else
            res[i] = int'(byte'(s));
`endif
        end
    endfunction

    // Later stages update first so each reads the previous contents.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_q[i] = 0; m_wq[i] = 0; m_res[i] = 0;
            end
        end else begin
            if (enable[2]) model_recon(m_wq, m_res);
            if (enable[1])
                for (int i = 0; i < 16; i++) m_wq[i] = model_dequant(m_q[i], qp_by_6, qp_mod_6, i);
            if (enable[0])
                for (int i = 0; i < 16; i++) m_q[i] = model_quant(transformed[i], qp_by_6, qp_mod_6, mode, i);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int bad_q;
        int bad_r;
        bad_q = -1;
        bad_r = -1;
        for (int i = 0; i < 16; i++) begin
            if (bad_q < 0 && int'(quantized[i]) != m_q[i]) bad_q = i;
            if (bad_r < 0 && int'(residuals[i]) != m_res[i]) bad_r = i;
        end
        n_compared += 2;
        if (bad_q >= 0) begin
            n_mismatched++;
            $display("[TB] FAIL model_quantized[%0d] @%0t: got %0d, expected %0d",
                     bad_q, $time, quantized[bad_q], m_q[bad_q]);
        end
        if (bad_r >= 0) begin
            n_mismatched++;
            $display("[TB] FAIL model_residuals[%0d] @%0t: got %0d, expected %0d",
                     bad_r, $time, residuals[bad_r], m_res[bad_r]);
        end
    end

    // ---------------- tasks ----------------
    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    task automatic checkAllResiduals(input string name, input int expected);
        for (int i = 0; i < 16; i++) checkOutput(name, int'(residuals[i]), expected);
    endtask

    // Drive a DC-only block (W[0]=w0) and advance one clock.
    task automatic applyStimulus(input int w0, input logic md, input int qpb, input int qpm,
                                 input logic [2:0] en);
        for (int i = 0; i < 16; i++) transformed[i] = 0;
        transformed[0] = w0;
        mode     = md;
        qp_by_6  = 4'(qpb);
        qp_mod_6 = 3'(qpm);
        enable   = en;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- directed sequence ----------------
    int pat_qp  [6][2] = '{'{0, 0}, '{1, 2}, '{2, 5}, '{3, 6}, '{5, 7}, '{8, 1}};
    logic [2:0] pat_en [6] = '{3'b111, 3'b111, 3'b011, 3'b110, 3'b111, 3'b101};

    initial begin
        reset    = 1'b1;
        enable   = 3'b111;
        mode     = 1'b0;
        qp_by_6  = 4'd4;
        qp_mod_6 = 3'd4;
        for (int i = 0; i < 16; i++) transformed[i] = int'($urandom_range(0, 20000)) - 10000;
        repeat (3) @(negedge clk);
        $display("[TB] reset hold");
        for (int i = 0; i < 16; i++) checkOutput("reset_quantized", int'(quantized[i]), 0);
        checkAllResiduals("reset_residuals", 0);
        reset = 1'b0;

        applyStimulus(0, 1'b0, 0, 0, 3'b111);
        applyStimulus(0, 1'b0, 0, 0, 3'b111);
        applyStimulus(0, 1'b0, 0, 0, 3'b111);
        checkAllResiduals("zero_block_residuals", 0);

        $display("[TB] QP0 latency");
        applyStimulus(10, 1'b0, 0, 0, 3'b111);
        checkOutput("qp0_latency1_z0", int'(quantized[0]), 4);
        checkOutput("qp0_latency1_res0", int'(residuals[0]), 0);
        applyStimulus(0, 1'b0, 0, 0, 3'b111);
        checkOutput("qp0_model_wq0", m_wq[0], 40);
        checkOutput("qp0_latency2_res0", int'(residuals[0]), 0);
        applyStimulus(0, 1'b0, 0, 0, 3'b111);
        checkAllResiduals("qp0_latency3_residuals", 1);
        repeat (3) applyStimulus(0, 1'b0, 0, 0, 3'b111);

        $display("[TB] invquant stall");
        applyStimulus(40, 1'b0, 0, 0, 3'b111);
        checkOutput("stall_z0", int'(quantized[0]), 16);
        applyStimulus(40, 1'b0, 0, 0, 3'b101);
        applyStimulus(40, 1'b0, 0, 0, 3'b111);
        checkOutput("stall_res0_held", int'(residuals[0]), 0);
        applyStimulus(0, 1'b0, 0, 0, 3'b111);
        checkOutput("stall_res0_late", int'(residuals[0]), 3);
        checkOutput("stall_res15_late", int'(residuals[15]), 3);
        repeat (3) applyStimulus(0, 1'b0, 0, 0, 3'b111);

        $display("[TB] QP 28 intra/inter");
        applyStimulus(64, 1'b0, 4, 4, 3'b111);
        checkOutput("qp28_pos_z0", int'(quantized[0]), 1);
        applyStimulus(-64, 1'b0, 4, 4, 3'b111);
        checkOutput("qp28_neg_z0", int'(quantized[0]), -1);
        checkOutput("qp28_model_wq0", m_wq[0], 256);
        applyStimulus(50, 1'b0, 4, 4, 3'b111);
        checkOutput("qp28_intra50_z0", int'(quantized[0]), 1);
        checkAllResiduals("qp28_pos_residuals", 4);
        applyStimulus(50, 1'b1, 4, 4, 3'b111);
        checkOutput("qp28_inter50_z0", int'(quantized[0]), 0);
        checkAllResiduals("qp28_neg_residuals", -4);
        applyStimulus(0, 1'b0, 4, 4, 3'b111);
        applyStimulus(0, 1'b0, 4, 4, 3'b111);
        checkAllResiduals("qp28_inter50_residuals", 0);

        $display("[TB] QP 51 large coefficient");
        applyStimulus(1 << 20, 1'b0, 8, 3, 3'b111);
        checkOutput("qp51_z0", int'(quantized[0]), 1170);
        applyStimulus(0, 1'b0, 8, 3, 3'b111);
        checkOutput("qp51_model_wq0", m_wq[0], 4193280);
        applyStimulus(0, 1'b0, 8, 3, 3'b111);
`ifdef QRECON_SAT_EN
        checkAllResiduals("qp51_saturated_residuals", 127);
`else
        checkAllResiduals("qp51_wrapped_residuals", -16);
`endif
        repeat (2) applyStimulus(0, 1'b0, 8, 3, 3'b111);

        $display("[TB] reset mid-operation");
        applyStimulus(64, 1'b0, 4, 4, 3'b111);
        applyStimulus(64, 1'b0, 4, 4, 3'b111);
        applyStimulus(64, 1'b0, 4, 4, 3'b111);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_z0", int'(quantized[0]), 0);
        checkAllResiduals("midreset_residuals", 0);
        @(negedge clk);
        checkOutput("midreset_hold_z0", int'(quantized[0]), 0);
        reset = 1'b0;

        $display("[TB] full-block patterns");
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 16; i++)
                transformed[i] = (((i * 53 + k * 97) % 401) - 200) * (k + 1) * 8;
            mode     = k[0];
            qp_by_6  = 4'(pat_qp[k][0]);
            qp_mod_6 = 3'(pat_qp[k][1]);
            enable   = pat_en[k];
            @(negedge clk);
        end
        repeat (4) applyStimulus(0, 1'b0, 2, 1, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
